median_lbuf_sched: RTL and testbench
====================================

// Module: median_lbuf_sched
// PURPOSE
//  Sequencer for the five 1x640x8 line buffers of the 5x5 median path. Decodes DPi sync/den, generates
//  per-buffer write/read enables and the shared RAM address, rotates the write pointer per line, appends
//  flush lines after the last active row, and publishes tap-select indices for the window-assembly mux.
//  Sits between the video input and the line-buffer bank; the median core consumes tap_sel and DPo_sync.
// PARAMETERS
//  H_ACTIVE     640  active pixels per line (lb_addr range 0..H_ACTIVE-1)
//  V_ACTIVE     480  active lines per frame
//  FLUSH_LINES  2    synthesized lines appended after row V_ACTIVE-1
//  FLUSH_GAP    46   cycles from hsync falling edge to first synthesized den
// PORTS
//  ref_clk    in   1   single clock
//  rst_n      in   1   synchronous active-low reset
//  DPi        in   11  [10]=vsync, [9]=hsync, [8]=den, [7:0]=pixel (pixel unused here)
//  lb_wr_en   out  5   one-hot write enable, bit i = line buffer i
//  lb_rd_en   out  5   read enable, = ~lb_wr_en
//  lb_addr    out  10  shared RAM address
//  tap_sel    out  15  5x3b buffer index per tap; [2:0]=oldest row .. [14:12]=newest row
//  DPo_sync   out  3   {vsync,hsync,den_eff} delayed 1 cycle (RAM read latency)
//  flush_busy out  1   high in FLUSH_GAP/FLUSH_LINE
//  frame_done out  1   1-cycle pulse on entry to DONE
//  line_err   out  1   1-cycle pulse on malformed line
// BEHAVIOUR
//  - Reset (rst_n=0 at ref_clk edge): state IDLE, xcnt/ycnt/wr_ptr/flush_cnt=0, syn_den=0; outputs:
//    lb_wr_en=0, lb_rd_en=5'h1F, lb_addr=0, tap_sel={3'd0,3'd4,3'd3,3'd2,3'd1}, DPo_sync=0,
//    flush_busy=0, frame_done=0, line_err=0. Reset mid-frame aborts everything; no write issued that cycle.
//  - den_eff = DPi[8] | syn_den. xcnt: cleared when vsync|hsync; else +1 on den_eff, saturates at H_ACTIVE.
//  - lb_addr = (xcnt==H_ACTIVE) ? H_ACTIVE-1 : xcnt (combinational). lb_wr_en[i] = den_eff && wr_ptr==i.
//  - Line end = hsync rising edge. xcnt==H_ACTIVE: ycnt+1, wr_ptr=(wr_ptr==4)?0:wr_ptr+1.
//    0<xcnt<H_ACTIVE: line_err pulse, ycnt/wr_ptr unchanged. xcnt==0: ignored (blanking line).
//  - tap_sel registered, updated cycle after wr_ptr changes: tap k (k=0..3) = (wr_ptr+1+k) mod 5, tap4 = wr_ptr.
//  - FSM:
//    IDLE       -> ACTIVE on vsync&&hsync (ycnt, wr_ptr cleared).
//    ACTIVE     -> FLUSH_GAP on hsync falling edge with ycnt==V_ACTIVE; capture L = row index of line V_ACTIVE-1.
//    FLUSH_GAP  counts FLUSH_GAP cycles from hsync fall, then -> FLUSH_LINE, syn_den=1.
//    FLUSH_LINE syn_den held exactly H_ACTIVE cycles; line end rotates wr_ptr as normal; flush_cnt+1;
//               -> FLUSH_GAP (next hsync fall) if flush_cnt<FLUSH_LINES, else DONE.
//    DONE       frame_done pulse on entry; -> ACTIVE on vsync&&hsync.
//  - vsync&&hsync in any state restarts the frame (ACTIVE, counters cleared, syn_den=0, flush aborted).
//  - Real DPi[8] high during FLUSH_GAP/FLUSH_LINE: line_err pulse; den still OR'd into den_eff.
//  - hsync rising during FLUSH_LINE before H_ACTIVE syn_den cycles: syn_den dropped, line_err pulse.
//  - Simultaneous vsync&&hsync and line end: frame restart wins; ycnt not incremented.
// CONFIGURATION
//  MEDIAN_SCHED_BORDER_REPLICATE_EN defined: during flush line j (j=0..FLUSH_LINES-1) lb_wr_en forced 0
//    (buffers keep real rows) and taps k>=4-j forced to L (bottom-row replication).
//  Not defined: flush lines write like active lines; tap_sel follows pure rotation.
// TESTING
//  1. Reset, one 640x480 frame -> wr_ptr sequence 0,1,2,3,4,0..; after row 4 tap_sel={3'd0,4,3,2,1}; ycnt=480.
//  2. Last active row -> FLUSH_GAP; syn_den rises exactly 46 cycles after hsync fall, lasts 640 cycles;
//     2 flush lines then frame_done single pulse; flush_busy high throughout.
//  3. Line with 600 den cycles -> line_err 1-cycle pulse, wr_ptr/ycnt unchanged, next good line writes same buffer.
//  4. vsync&&hsync asserted mid-FLUSH_LINE -> syn_den=0 next cycle, state ACTIVE, wr_ptr=0, no frame_done.
//  5. Macro on, flush line 0 with L=4: lb_wr_en=0 all cycles, tap_sel[14:12]=4; flush line 1: taps 3,4 = 4.
//  6. rst_n=0 at pixel 300 of row 10 -> all outputs at reset values next cycle; next vsync restarts cleanly.

Source files
------------

// File: rtl/median_lbuf_sched.sv
// median_lbuf_sched: sequencer for the five line buffers of the 5x5 median path.
// Decodes DPi sync/den and drives the per-buffer write/read enables and the shared
// RAM address. It rotates the write pointer once per completed line and appends
// synthesized flush lines after the last active row. It also publishes the
// tap-select indices used by the window-assembly mux.
// Optional build macro: MEDIAN_SCHED_BORDER_REPLICATE_EN. When it is defined, the
// flush lines do not write the buffers and the bottom real row is replicated into
// the newest taps.
// Handshake: there is no valid/ready pair. DPi is sampled every ref_clk cycle.
// A buffer accepts a write in any cycle where its lb_wr_en bit is high.
module median_lbuf_sched #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int FLUSH_LINES = 2,
   parameter int FLUSH_GAP   = 46
) (
   input  logic        ref_clk,
   input  logic        rst_n,
   input  logic [10:0] DPi,
   output logic [4:0]  lb_wr_en,
   output logic [4:0]  lb_rd_en,
   output logic [9:0]  lb_addr,
   output logic [14:0] tap_sel,
   output logic [2:0]  DPo_sync,
   output logic        flush_busy,
   output logic        frame_done,
   output logic        line_err,
   output logic [2:0]  o_dbg_state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACTIVE = 3'd1;
   localparam logic [2:0] S_GAP    = 3'd2;
   localparam logic [2:0] S_LINE   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [9:0]  H_MAX    = 10'(H_ACTIVE);
   localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE - 1);
   localparam logic [10:0] V_END    = 11'(V_ACTIVE);
   localparam logic [7:0]  GAP_LAST = 8'(FLUSH_GAP - 1);
   localparam logic [2:0]  FL_N     = 3'(FLUSH_LINES);
   localparam logic [14:0] TAP_RST  = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1};

   logic [2:0]  r_state;
   logic        r_hs_d;
   logic [9:0]  r_xcnt;
   logic [10:0] r_ycnt;
   logic [2:0]  r_wr_ptr;
   logic [2:0]  r_flush_cnt;
   logic [7:0]  r_gap_cnt;
   logic        r_syn_den;
   logic [14:0] r_tap;
   logic [2:0]  r_dpo;
   logic        r_frame_done;
   logic        r_line_err;
`ifdef MEDIAN_SCHED_BORDER_REPLICATE_EN
   logic [2:0]  r_last_ptr;
`endif

   logic        w_vs;
   logic        w_hs;
   logic        w_den_eff;
   logic        w_restart;
   logic        w_hs_rise;
   logic        w_hs_fall;
   logic        w_line_end;
   logic        w_flushing;
   logic [2:0]  w_ptr_next;
   logic [14:0] w_tap_next;
   logic        w_unused_pixel;

   // (a + b) mod 5 for a in 0..4, b in 0..4
   function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
   endfunction

   assign w_vs           = DPi[10];
   assign w_hs           = DPi[9];
   assign w_den_eff      = DPi[8] | r_syn_den;
   assign w_unused_pixel = ^DPi[7:0];
   assign w_restart      = w_vs & w_hs;
   assign w_hs_rise      = w_hs & ~r_hs_d;
   assign w_hs_fall      = ~w_hs & r_hs_d;
   // A frame restart on the same cycle swallows the line end.
   assign w_line_end     = w_hs_rise & ~w_restart & (r_state != S_IDLE);
   assign w_flushing     = (r_state == S_GAP) | (r_state == S_LINE);
   assign w_ptr_next     = (r_wr_ptr == 3'd4) ? 3'd0 : r_wr_ptr + 3'd1;

   assign lb_rd_en    = ~lb_wr_en;
   assign lb_addr     = (r_xcnt == H_MAX) ? H_LAST : r_xcnt;
   assign tap_sel     = r_tap;
   assign DPo_sync    = r_dpo;
   assign flush_busy  = w_flushing;
   assign frame_done  = r_frame_done;
   assign line_err    = r_line_err;
   assign o_dbg_state = r_state;

   // Write enable: one-hot on the current write pointer, suppressed while in reset
   always_comb begin
      lb_wr_en = '0;
      if (rst_n && w_den_eff) lb_wr_en = 5'(5'd1 << r_wr_ptr);
`ifdef MEDIAN_SCHED_BORDER_REPLICATE_EN
      if (r_state == S_LINE) lb_wr_en = '0;
`endif
   end

   // Next tap selection: pure rotation, optionally replicating the last real row
   always_comb begin
      w_tap_next = '0;
      for (int k = 0; k < 4; k++) w_tap_next[3*k +: 3] = mod5_add(r_wr_ptr, 3'(k + 1));
      w_tap_next[14:12] = r_wr_ptr;
`ifdef MEDIAN_SCHED_BORDER_REPLICATE_EN
      if (r_state == S_LINE) begin
         for (int k = 0; k < 5; k++)
            if (k >= 4 - int'(r_flush_cnt)) w_tap_next[3*k +: 3] = r_last_ptr;
      end
`endif
   end

   // Pixel counter and hsync history for edge detection
   always_ff @(posedge ref_clk) begin
      if (!rst_n) begin
         r_xcnt <= '0;
         r_hs_d <= 1'b0;
      end else begin
         r_hs_d <= w_hs;
         if (w_vs | w_hs)                          r_xcnt <= '0;
         else if (w_den_eff && (r_xcnt != H_MAX))  r_xcnt <= r_xcnt + 10'd1;
      end
   end

   // Registered tap indices and one-cycle delayed sync for the RAM read latency
   always_ff @(posedge ref_clk) begin
      if (!rst_n) begin
         r_tap <= TAP_RST;
         r_dpo <= '0;
      end else begin
         r_tap <= w_tap_next;
         r_dpo <= {w_vs, w_hs, w_den_eff};
      end
   end

   // Frame sequencer: line accounting, flush gap/line generation, error pulses
   always_ff @(posedge ref_clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ycnt       <= '0;
         r_wr_ptr     <= '0;
         r_flush_cnt  <= '0;
         r_gap_cnt    <= '0;
         r_syn_den    <= 1'b0;
         r_frame_done <= 1'b0;
         r_line_err   <= 1'b0;
`ifdef MEDIAN_SCHED_BORDER_REPLICATE_EN
         r_last_ptr   <= '0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         // Short line, truncated flush line, or real den inside the flush window
         r_line_err   <= (w_line_end && (r_xcnt != '0) && (r_xcnt != H_MAX)) ||
                         (w_line_end && r_syn_den) ||
                         (DPi[8] && w_flushing);
         if (w_restart) begin
            r_state     <= S_ACTIVE;
            r_ycnt      <= '0;
            r_wr_ptr    <= '0;
            r_flush_cnt <= '0;
            r_gap_cnt   <= '0;
            r_syn_den   <= 1'b0;
         end else begin
            if (w_line_end && (r_xcnt == H_MAX)) begin
               r_ycnt   <= r_ycnt + 11'd1;
               r_wr_ptr <= w_ptr_next;
            end
            case (r_state)
               S_ACTIVE: begin
                  if (w_hs_fall && (r_ycnt == V_END)) begin
                     r_state   <= S_GAP;
                     r_gap_cnt <= 8'd1;
`ifdef MEDIAN_SCHED_BORDER_REPLICATE_EN
                     // Buffer that holds the bottom real row
                     r_last_ptr <= (r_wr_ptr == 3'd0) ? 3'd4 : r_wr_ptr - 3'd1;
`endif
                  end
               end
               S_GAP: begin
                  if (r_gap_cnt == GAP_LAST) begin
                     r_state   <= S_LINE;
                     r_syn_den <= 1'b1;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + 8'd1;
                  end
               end
               S_LINE: begin
                  if (w_line_end) begin
                     r_syn_den   <= 1'b0;
                     r_flush_cnt <= r_flush_cnt + 3'd1;
                     if ((r_flush_cnt + 3'd1) >= FL_N) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                     end
                  end else if (r_syn_den && w_den_eff && (r_xcnt == H_LAST)) begin
                     r_syn_den <= 1'b0;
                  end else if (w_hs_fall && !r_syn_den) begin
                     r_state   <= S_GAP;
                     r_gap_cnt <= 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_median_lbuf_sched.sv
// Bench for median_lbuf_sched on a reduced 16x10 frame. It uses the full flush
// gap and flush-line count.
module tb_median_lbuf_sched;

   localparam int H   = 16;
   localparam int V   = 10;
   localparam int FG  = 46;
   localparam int FL  = 2;
   localparam int HSW = 4;
   localparam int LOW = 70;
`ifdef MEDIAN_SCHED_BORDER_REPLICATE_EN
   localparam bit REPL = 1'b1;
`else
   localparam bit REPL = 1'b0;
`endif

   logic        ref_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic [10:0] DPi     = '0;
   logic [4:0]  lb_wr_en, lb_rd_en;
   logic [9:0]  lb_addr;
   logic [14:0] tap_sel;
   logic [2:0]  DPo_sync, dbg_state;
   logic        flush_busy, frame_done, line_err;

   median_lbuf_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .FLUSH_LINES(FL), .FLUSH_GAP(FG)) dut (
      .ref_clk(ref_clk), .rst_n(rst_n), .DPi(DPi),
      .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr), .tap_sel(tap_sel),
      .DPo_sync(DPo_sync), .flush_busy(flush_busy), .frame_done(frame_done),
      .line_err(line_err), .o_dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 ref_clk = ~ref_clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: lines completed since frame start, pixels seen this line
   int          m_good, m_x, m_tap_src;
   logic        m_active, m_prev_hs, m_err;
   logic [2:0]  m_prev_in;
   bit          chk_en;
   int          err_seen, done_seen;

   // samples of the most recent cycle
   logic [4:0]  s_wr;
   logic [14:0] s_tap;
   logic [2:0]  s_dpo;
   logic        s_busy, s_done;
   logic [40:0] s_all;

   typedef struct {
      int n_den;
      bit exp_err;
   } line_vec_t;
   line_vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [14:0] rot_taps(input int p);
      logic [14:0] t;
      t = '0;
      for (int k = 0; k < 4; k++) t[3*k +: 3] = 3'((p + 1 + k) % 5);
      t[14:12] = 3'(p);
      return t;
   endfunction

   function automatic logic [14:0] flush_taps(input int j);
      logic [14:0] t;
      t = rot_taps((V + j) % 5);
      if (REPL)
         for (int k = 0; k < 5; k++) if (k >= 4 - j) t[3*k +: 3] = 3'((V - 1) % 5);
      return t;
   endfunction

   task automatic model_reset();
      m_good = 0; m_x = 0; m_tap_src = 0;
      m_active = 1'b0; m_prev_hs = 1'b0; m_err = 1'b0; m_prev_in = '0;
   endtask

   // one clock: drive, sample at negedge, compare, advance model
   task automatic step(input logic vs, input logic hs, input logic den);
      logic [40:0] exp_all;
      logic [4:0]  exp_wr;
      logic [9:0]  exp_addr;
      DPi = {vs, hs, den, 8'($urandom)};
      @(negedge ref_clk);
      s_wr = lb_wr_en; s_tap = tap_sel; s_dpo = DPo_sync;
      s_busy = flush_busy; s_done = frame_done;
      s_all = {lb_wr_en, lb_rd_en, lb_addr, tap_sel, DPo_sync, flush_busy, frame_done, line_err};
      err_seen  += int'(line_err);
      done_seen += int'(frame_done);
      if (chk_en) begin
         exp_wr   = den ? 5'(5'd1 << (m_good % 5)) : 5'd0;
         exp_addr = (m_x >= H) ? 10'(H - 1) : 10'(m_x);
         exp_all  = {exp_wr, ~exp_wr, exp_addr, rot_taps(m_tap_src), m_prev_in, 1'b0, 1'b0, m_err};
         chk("cycle", 64'(s_all), 64'(exp_all));
      end
      m_tap_src = m_good % 5;
      m_err = 1'b0;
      if (vs && hs) begin
         m_good = 0; m_active = 1'b1;
      end else if (hs && !m_prev_hs && m_active) begin
         if (m_x == H) m_good++;
         else if (m_x > 0) m_err = 1'b1;
      end
      if (vs || hs) m_x = 0;
      else if (den && m_x < H) m_x++;
      m_prev_hs = hs;
      m_prev_in = {vs, hs, den};
      @(posedge ref_clk); #1;
   endtask

   task automatic do_line(input int n_den, input bit vs);
      for (int i = 0; i < HSW; i++) step(vs, 1'b1, 1'b0);
      for (int i = 0; i < LOW; i++) step(1'b0, 1'b0, (i >= 3) && (i < 3 + n_den));
   endtask

   task automatic blank_mon(output int syn_start, output int syn_len, output int busy_cnt,
                            output int done_cnt, output int done_idx,
                            output logic [4:0] wr50, output logic [14:0] tap50);
      syn_start = -1; syn_len = 0; busy_cnt = 0; done_cnt = 0; done_idx = -1;
      wr50 = '0; tap50 = '0;
      for (int i = 0; i < HSW + LOW; i++) begin
         int j;
         j = i - HSW;
         step(1'b0, (i < HSW), 1'b0);
         if (j >= 0 && s_dpo[0]) begin
            if (syn_start < 0) syn_start = j;
            syn_len++;
         end
         if (s_busy) busy_cnt++;
         if (s_done) begin done_cnt++; done_idx = i; end
         if (j == 50) begin wr50 = s_wr; tap50 = s_tap; end
      end
   endtask

   task automatic chk_reset_vals(input string name);
      logic [40:0] exp_rst;
      exp_rst = {5'd0, 5'h1F, 10'd0, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0};
      chk(name, 64'(s_all), 64'(exp_rst));
   endtask

   initial begin
      int ss, sl, bc, dc, di, nl, nd;
      logic [4:0]  w50;
      logic [14:0] t50;

      tbl[0] = '{16, 1'b0}; tbl[1] = '{16, 1'b0}; tbl[2] = '{10, 1'b1}; tbl[3] = '{16, 1'b0};
      tbl[4] = '{0,  1'b0}; tbl[5] = '{1,  1'b1}; tbl[6] = '{16, 1'b0}; tbl[7] = '{30, 1'b0};

      // reset state
      model_reset();
      chk_en = 1'b0;
      repeat (3) @(posedge ref_clk);
      @(negedge ref_clk);
      s_all = {lb_wr_en, lb_rd_en, lb_addr, tap_sel, DPo_sync, flush_busy, frame_done, line_err};
      chk_reset_vals("reset_state");
      @(posedge ref_clk); #1;
      rst_n = 1'b1;

      // table: malformed and saturating lines; the error pulse shows up in the following line
      chk_en = 1'b1;
      do_line(0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         err_seen = 0;
         do_line(tbl[i].n_den, 1'b0);
         if (i > 0) chk($sformatf("tbl_err[%0d]", i - 1), 64'(err_seen), 64'(tbl[i-1].exp_err));
      end
      err_seen = 0;
      do_line(0, 1'b0);
      chk("tbl_err[7]", 64'(err_seen), 64'(tbl[7].exp_err));

      // random frames, each shorter than V good lines
      for (int f = 0; f < 4; f++) begin
         do_line(0, 1'b1);
         nl = $urandom_range(3, 8);
         for (int l = 0; l < nl; l++) begin
            case ($urandom_range(0, 3))
               0:       nd = H;
               1:       nd = 0;
               2:       nd = $urandom_range(1, H - 1);
               default: nd = $urandom_range(H + 1, 40);
            endcase
            do_line(nd, 1'b0);
         end
      end

      // full frame followed by the flush sequence
      do_line(0, 1'b1);
      for (int l = 0; l < V; l++) do_line(H, 1'b0);
      chk_en = 1'b0;
      err_seen = 0; done_seen = 0;
      blank_mon(ss, sl, bc, dc, di, w50, t50);
      chk("fl0_syn_start", 64'(ss), 64'(FG + 1));
      chk("fl0_syn_len",   64'(sl), 64'(H));
      chk("fl0_busy_cnt",  64'(bc), 64'(LOW - 1));
      chk("fl0_done_cnt",  64'(dc), 64'(0));
      chk("fl0_wr_en",     64'(w50), REPL ? 64'(0) : 64'(5'd1 << (V % 5)));
      chk("fl0_tap_sel",   64'(t50), 64'(flush_taps(0)));
      blank_mon(ss, sl, bc, dc, di, w50, t50);
      chk("fl1_syn_start", 64'(ss), 64'(FG + 1));
      chk("fl1_syn_len",   64'(sl), 64'(H));
      chk("fl1_busy_cnt",  64'(bc), 64'(HSW + LOW));
      chk("fl1_wr_en",     64'(w50), REPL ? 64'(0) : 64'(5'd1 << ((V + 1) % 5)));
      chk("fl1_tap_sel",   64'(t50), 64'(flush_taps(1)));
      blank_mon(ss, sl, bc, dc, di, w50, t50);
      chk("done_pulses",   64'(dc), 64'(1));
      chk("done_position", 64'(di), 64'(1));
      chk("post_syn_len",  64'(sl), 64'(0));
      chk("post_busy_cnt", 64'(bc), 64'(1));
      chk("flush_line_err", 64'(err_seen), 64'(0));
      chk("flush_done_tot", 64'(done_seen), 64'(1));

      // restart in the middle of a flush line
      do_line(0, 1'b1);
      chk_en = 1'b1;
      for (int l = 0; l < V; l++) do_line(H, 1'b0);
      chk_en = 1'b0;
      done_seen = 0;
      for (int i = 0; i < HSW; i++) step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("abort_busy",  64'(s_busy), 64'(0));
      chk("abort_wr_en", 64'(s_wr), 64'(0));
      chk("abort_dpo0",  64'(s_dpo), 64'(3'b111));
      step(1'b1, 1'b1, 1'b0);
      chk("abort_dpo1",  64'(s_dpo), 64'(3'b110));
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < LOW; i++) step(1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      do_line(H, 1'b0);
      do_line(H, 1'b0);
      do_line(0, 1'b0);
      chk("abort_no_done", 64'(done_seen), 64'(0));

      // reset in the middle of a row, then a clean restart
      do_line(0, 1'b1);
      for (int l = 0; l < 3; l++) do_line(H, 1'b0);
      for (int i = 0; i < HSW; i++) step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, (i >= 3));
      chk_en = 1'b0;
      rst_n = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk_reset_vals("midrow_reset");
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < LOW - 13; i++) step(1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      do_line(0, 1'b1);
      do_line(H, 1'b0);
      do_line(H, 1'b0);
      do_line(0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
